// File: rtl/frame_ram_writer.sv
// Streams one IMG_W x IMG_H image of pixels into a selected slot of the frame RAM through its write port (port B).
// Addresses come from a running pointer, so the per-pixel path has no multiplier.
module frame_ram_writer #(
   parameter int IMG_W   = 460,
   parameter int IMG_H   = 460,
   parameter int NUM_IMG = 2,
   parameter int ADDR_W  = 19,
   parameter int DATA_W  = 8,
   localparam int SEL_W  = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SEL_W-1:0]  img_sel,
   input  logic              abort,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   output logic              busy,
   output logic              done,
   output logic              err_len
);

   localparam int COL_W = $clog2(IMG_W + 1);
   localparam int ROW_W = $clog2(IMG_H + 1);
   localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(IMG_W * IMG_H);

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;

   logic              accept;
   logic              last_pix;
   logic              sel_ok;
   logic [ADDR_W-1:0] slot_base;

   assign s_ready   = (state == LOAD);
   assign busy      = (state == LOAD);
   assign accept    = s_valid & s_ready;
   assign last_pix  = (col == COL_W'(IMG_W - 1)) && (row == ROW_W'(IMG_H - 1));
   assign sel_ok    = int'(img_sel) < NUM_IMG;
   // The only multiply: slot base, evaluated once per accepted start.
   assign slot_base = ADDR_W'(img_sel) * FRAME_SZ;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         col      <= '0;
         row      <= '0;
         ram_addr <= '0;
         ram_data <= '0;
         ram_wren <= 1'b0;
         done     <= 1'b0;
         err_len  <= 1'b0;
      end else begin
         // NOTE: single-cycle strobes get a default here and are overridden below, so they never stick high.
         ram_wren <= accept;
         done     <= 1'b0;

         if (accept) begin
            ram_addr <= wr_ptr;
            ram_data <= s_data;
            wr_ptr   <= wr_ptr + 1'b1;
            if (col == COL_W'(IMG_W - 1)) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            // s_last is only cross-checked; the pixel count alone ends the frame.
            if (s_last != last_pix) err_len <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  if (sel_ok) begin
                     state   <= LOAD;
                     wr_ptr  <= slot_base;
                     col     <= '0;
                     row     <= '0;
                     err_len <= 1'b0;
                  end else begin
                     err_len <= 1'b1;
                  end
               end
            end
            LOAD: begin
               // Abort beats completion; the write already captured for this beat still goes out.
               if (abort) begin
                  state <= IDLE;
               end else if (accept && last_pix) begin
                  state <= FLUSH;
                  done  <= 1'b1;
               end
            end
            FLUSH:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_ram_writer.sv
// Randomized directed bench for frame_ram_writer on a reduced 12x10, 3-slot geometry.
// Expected writes and flags come from a beat-counting model of the loader rules.
module tb_frame_ram_writer;

   localparam int IMG_W   = 12;
   localparam int IMG_H   = 10;
   localparam int NUM_IMG = 3;
   localparam int ADDR_W  = 19;
   localparam int DATA_W  = 8;
   localparam int FRAME   = IMG_W * IMG_H;

   logic              clk;
   logic              rst;
   logic              start;
   logic [1:0]        img_sel;
   logic              abort;
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              s_ready;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic              ram_wren;
   logic              busy;
   logic              done;
   logic              err_len;

   frame_ram_writer #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_IMG(NUM_IMG), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .img_sel(img_sel), .abort(abort),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
      .busy(busy), .done(done), .err_len(err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: loading flag, slot base, beats taken, sticky length error.
   bit m_load  = 0;
   bit m_flush = 0;
   bit m_err   = 0;
   int m_base  = 0;
   int m_cnt   = 0;
   int wr_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic l,
                       input logic st, input logic [1:0] sel, input logic ab);
      bit acc;
      bit fin;
      int exp_addr;
      s_valid = v; s_data = d; s_last = l; start = st; img_sel = sel; abort = ab;
      acc      = v && m_load;
      fin      = acc && (m_cnt == FRAME - 1);
      exp_addr = m_base + m_cnt;
      if (m_load) begin
         if (acc) begin
            if (l != fin) m_err = 1;
            m_cnt++;
         end
         if (ab) m_load = 0;
         else if (fin) begin
            m_load  = 0;
            m_flush = 1;
         end
      end else if (m_flush) begin
         m_flush = 0;
      end else if (st) begin
         if (sel >= NUM_IMG) m_err = 1;
         else begin
            m_load = 1; m_base = sel * FRAME; m_cnt = 0; m_err = 0;
         end
      end
      @(posedge clk); #1;
      if (ram_wren) wr_seen++;
      chk("wren", ram_wren, acc);
      if (acc) begin
         chk("addr", ram_addr, exp_addr);
         chk("data", ram_data, d);
      end
      chk("done", done, fin && !ab);
      chk("busy", busy, m_load);
      chk("s_ready", s_ready, m_load);
      chk("err_len", err_len, m_err);
   endtask

   task automatic idle();
      step(0, 8'h00, 0, 0, 2'd0, 0);
   endtask

   // One load: gaps carry random junk and stray starts; abort_at = beat count at which to abort (-1: never).
   task automatic load(input logic [1:0] sel, input int gap_pct, input int last_idx,
                       input int abort_at, input bit abort_on_final);
      int sent = 0;
      wr_seen = 0;
      step(0, 8'h00, 0, 1, sel, 0);
      while (sent < FRAME) begin
         if (sent == abort_at) begin
            step(0, 8'h00, 0, 0, 2'd0, 1);
            break;
         end
         if (int'($urandom_range(99)) < gap_pct) begin
            step(0, 8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), 2'd0, 0);
         end else begin
            step(1, 8'($urandom), sent == last_idx, 0, 2'd0, abort_on_final && (sent == FRAME - 1));
            sent++;
         end
      end
      if (m_flush) step(0, 8'h00, 0, 1, 2'd1, 1);
      idle();
      chk("writes", wr_seen, (abort_at >= 0 && abort_at < FRAME) ? abort_at : FRAME);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1; start = 0; img_sel = 0; abort = 0; s_valid = 0; s_data = 0; s_last = 0;
      #3;
      chk("rst_ready", s_ready, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_len, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_data", ram_data, 0);
      @(posedge clk); #1;
      rst = 0;
      idle();

      // Full slot-0 load, no gaps; abort while idle has no effect.
      step(0, 8'h00, 0, 0, 2'd0, 1);
      load(2'd0, 0, FRAME - 1, -1, 0);

      // Slot 1 with random gaps and stray starts during the load.
      load(2'd1, 40, FRAME - 1, -1, 0);

      // Early s_last at pixel 5, none on the final pixel: error, frame still completes.
      load(2'd2, 20, 5, -1, 0);

      // Abort after 50 beats, then a fresh load must start again at the slot base.
      load(2'd1, 25, FRAME - 1, 50, 0);
      load(2'd0, 10, FRAME - 1, -1, 0);

      // Abort coinciding with the final beat: write still issues, no done.
      load(2'd2, 0, FRAME - 1, -1, 1);

      // Invalid slot: stays idle with err_len; a valid start then clears it.
      step(0, 8'h00, 0, 1, 2'd3, 0);
      idle();
      load(2'd1, 15, FRAME - 1, -1, 0);

      // Asynchronous reset mid-load with a write pending.
      step(0, 8'h00, 0, 1, 2'd1, 0);
      for (int i = 0; i < 30; i++) step(1, 8'($urandom), 0, 0, 2'd0, 0);
      chk("pre_rst_wren", ram_wren, 1);
      #2 rst = 1;
      #1;
      chk("arst_ready", s_ready, 0);
      chk("arst_wren", ram_wren, 0);
      chk("arst_busy", busy, 0);
      chk("arst_addr", ram_addr, 0);
      chk("arst_err", err_len, 0);
      m_load = 0; m_flush = 0; m_err = 0; m_cnt = 0; m_base = 0;
      @(posedge clk); #1;
      rst = 0;
      idle();
      idle();
      load(2'd0, 30, FRAME - 1, -1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
